// File: rtl/booth_iter_mul_ctrl.sv
// Iterative radix-4 Booth multiplier, 16x16 signed -> 32-bit product.
// One Booth digit per cycle through a single shared encoder.
module booth_iter_mul_ctrl #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy,
    output logic [2:0]  digit_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH != 16) begin : g_width_check
        $error("booth_iter_mul_ctrl: WIDTH must be 16");
    end

    logic [1:0]  state;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [31:0] acc;
    logic [31:0] prod;
    logic [2:0]  idx;
    logic        drain;

    logic [16:0] b_ext;
    logic [2:0]  win;
    logic [17:0] a_x;
    logic [17:0] pp;
    logic [31:0] pp_sh;
    logic [31:0] acc_nx;
    logic [15:0] rest;
    logic        rest_zero;
    logic        last;

    assign b_ext = {b_r, 1'b0};
    assign win   = b_ext[{idx, 1'b0} +: 3];
    assign a_x   = {{2{a_r[15]}}, a_r};

    // 18 bits so that -2A stays exact for A = -32768
    always_comb begin
        pp = '0;
        case (win)
            3'b001, 3'b010: pp = a_x;
            3'b011:         pp = a_x << 1;
            3'b100:         pp = ~(a_x << 1) + 18'd1;
            3'b101, 3'b110: pp = ~a_x + 18'd1;
            default:        pp = '0;
        endcase
    end

    assign pp_sh  = {{14{pp[17]}}, pp} << {idx, 1'b0};
    assign acc_nx = acc + pp_sh;

    // remaining digits are all zero when B[15:2i+1] is all 0s or all 1s
    assign rest      = $signed(b_r) >>> ({idx, 1'b0} + 4'd1);
    assign rest_zero = (rest == '0) || (rest == '1);
    assign last      = (idx == 3'd7) || (EARLY_TERM && rest_zero);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            prod  <= '0;
            idx   <= '0;
            drain <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        acc   <= '0;
                        idx   <= '0;
                        drain <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // final cycle loads the product from the settled accumulator
                    if (drain) begin
                        prod  <= acc;
                        drain <= 1'b0;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        acc <= acc_nx;
                        if (last) begin
                            drain <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);
    assign digit_idx = (state == BUSY && !drain) ? idx : 3'd0;
    assign out_p     = prod;

endmodule

// File: tb/tb_booth_iter_mul_ctrl.sv
// Directed and random checks for booth_iter_mul_ctrl.
// Unit 0 runs full iteration, unit 1 terminates early.
module tb_booth_iter_mul_ctrl;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][15:0] in_a;
    logic [1:0][15:0] in_b;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][31:0] out_p;
    logic [1:0]       busy;
    logic [1:0][2:0]  digit_idx;

    int nvec = 0;
    int nfail = 0;
    int hs[2] = '{0, 0};
    int ops[2] = '{0, 0};
    int bad_rdy = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        booth_iter_mul_ctrl #(
            .WIDTH(16),
            .EARLY_TERM(g == 1)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_a(in_a[g]),
            .in_b(in_b[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_p(out_p[g]),
            .busy(busy[g]),
            .digit_idx(digit_idx[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n && out_valid[u] && out_ready[u]) hs[u]++;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n && in_ready[u] && busy[u]) bad_rdy++;
        end
    end

    typedef struct {
        int          u;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int et_lat(input logic [15:0] b);
        logic signed [15:0] r;
        for (int k = 1; k <= 8; k++) begin
            r = $signed(b) >>> (2 * k - 1);
            if (r == '0 || r == '1) return 1 + k;
        end
        return 9;
    endfunction

    task automatic run_op(input int u, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp,
                          input int lat, input int hold);
        int n;
        @(negedge clk);
        in_a[u] = a;
        in_b[u] = b;
        in_valid[u] = 1'b1;
        ops[u]++;
        n = 0;
        while (!in_ready[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(in_ready[u]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        n = 0;
        while (!out_valid[u] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("valid", 32'(out_valid[u]), 32'd1);
        check("product", out_p[u], exp);
        // backpressure: new operands offered but must be ignored
        in_a[u] = ~a;
        in_b[u] = ~b;
        in_valid[u] = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid[u]), 32'd1);
            check("hold_p", out_p[u], exp);
            check("hold_no_rdy", 32'(in_ready[u]), 32'd0);
        end
        in_valid[u] = 1'b0;
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        check("valid_drop", 32'(out_valid[u]), 32'd0);
        check("ready_again", 32'(in_ready[u]), 32'd1);
        check("p_kept", out_p[u], exp);
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] ra;
        logic [15:0] rb;
        int sa;
        int sb;

        tbl[0]  = '{0, 16'd3,    16'd5,    32'h0000000F, 9};
        tbl[1]  = '{0, 16'h8000, 16'h8000, 32'h40000000, 9};
        tbl[2]  = '{0, 16'h7FFF, 16'h8000, 32'hC0008000, 9};
        tbl[3]  = '{0, 16'hFFFF, 16'h0007, 32'hFFFFFFF9, 9};
        tbl[4]  = '{0, 16'h0000, 16'h1234, 32'h00000000, 9};
        tbl[5]  = '{1, 16'd100,  16'h0001, 32'h00000064, 2};
        tbl[6]  = '{1, 16'd100,  16'hFFFF, 32'hFFFFFF9C, 2};
        tbl[7]  = '{1, 16'd3,    16'h4000, 32'h0000C000, 9};
        tbl[8]  = '{1, 16'h8000, 16'h8000, 32'h40000000, 9};
        tbl[9]  = '{1, 16'h0000, 16'h1234, 32'h00000000, 8};
        tbl[10] = '{1, 16'd5,    16'h0000, 32'h00000000, 2};
        tbl[11] = '{1, 16'hFFFD, 16'h0006, 32'hFFFFFFEE, 3};

        in_valid = '0;
        out_ready = '0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", 32'(in_ready[u]), 32'd1);
            check("rst_out_valid", 32'(out_valid[u]), 32'd0);
            check("rst_out_p", out_p[u], 32'd0);
            check("rst_busy", 32'(busy[u]), 32'd0);
            check("rst_digit", 32'(digit_idx[u]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].u, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, 0);
        end

        run_op(0, 16'd3, 16'd5, 32'h0000000F, 9, 5);

        // abort mid-operation with a one-cycle reset
        @(negedge clk);
        in_a[0] = 16'd1000;
        in_b[0] = 16'd1000;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (digit_idx[0] != 3'd4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_digit4", 32'(digit_idx[0]), 32'd4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready[0]), 32'd1);
        check("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check("abort_out_p", out_p[0], 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_digit", 32'(digit_idx[0]), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) seen++;
        end
        check("abort_no_valid", seen, 32'd0);
        run_op(0, 16'd2, 16'd3, 32'h00000006, 9, 0);

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 150; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                sa = $signed(ra);
                sb = $signed(rb);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_op(u, ra, rb, 32'(sa * sb),
                       (u == 0) ? 9 : et_lat(rb), $urandom_range(0, 3));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("handshakes_u0", hs[0], ops[0]);
        check("handshakes_u1", hs[1], ops[1]);
        check("ready_while_busy", bad_rdy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
